// File: rtl/spi_reg_burst.sv
// spi_reg_burst: SPI slave to register-bus bridge with burst access.
//
// The first SPI word of a frame is a command {rw, pad, addr}; every following word is
// write data (rw=0) or read data (rw=1) at an address that auto-increments per word and
// wraps modulo 2^ADDR_W. SPI mode is fixed at elaboration through CPOL/CPHA.
//
// Ports:
//   i_clk, i_rst, i_ena        system clock, synchronous active-high reset, clock enable
//   i_spi_clk/cs_n/mosi        asynchronous SPI pins (synchronised internally)
//   o_spi_miso                 SPI data out, MSB first
//   i_status                   word shifted out during the command word
//   o_reg_addr                 current register access address
//   o_reg_wdata, o_reg_wr_en   write data with single-cycle write strobe
//   o_reg_rd_en, i_reg_rdata   single-cycle read request; data returned one clk later
//   o_frame_active             high while a frame is being serviced
module spi_reg_burst #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned REG_W  = 8,
    parameter int unsigned CPOL   = 0,
    parameter int unsigned CPHA   = 1,
    parameter int unsigned SYNC_N = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ena,
    input  logic              i_spi_clk,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    input  logic [REG_W-1:0]  i_status,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [REG_W-1:0]  o_reg_wdata,
    output logic              o_reg_wr_en,
    output logic              o_reg_rd_en,
    input  logic [REG_W-1:0]  i_reg_rdata,
    output logic              o_frame_active
);

    localparam int unsigned CNT_W = (REG_W > 1) ? $clog2(REG_W) : 1;
    localparam int unsigned FL_W  = $clog2(SYNC_N + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(REG_W - 1);
    // Change edge on which the tx shifter holds: with CPHA=1 the first (leading) edge of a
    // word, since the MSB is already presented; with CPHA=0 the trailing edge after the last
    // sample, since the next word may already be loaded.
    localparam logic [CNT_W-1:0] SKIP_CHG = (CPHA == 0) ? CNT_W'(REG_W - 1) : '0;
    localparam logic [FL_W-1:0]  FL_MAX   = FL_W'(SYNC_N);
    localparam logic SCK_IDLE    = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_N-1:0] r_sck_sync;
    logic [SYNC_N-1:0] r_cs_sync;
    logic [SYNC_N-1:0] r_mosi_sync;
    logic              r_sck_last;
    logic              r_cs_last;
    logic [FL_W-1:0]   r_flush_cnt;
    logic              r_armed;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  r_chg_cnt;
    logic [REG_W-2:0]  r_rx;
    logic [REG_W-1:0]  r_tx;
    logic [ADDR_W-1:0] r_addr;
    logic [REG_W-1:0]  r_wdata;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              r_rd_pend;

    logic              w_sck;
    logic              w_cs;
    logic              w_mosi;
    logic              w_rise;
    logic              w_fall;
    logic              w_sample;
    logic              w_change;
    logic              w_sof;
    logic              w_eof;
    logic              w_busy;
    logic              w_bit;
    logic              w_done;
    logic [REG_W-1:0]  w_word;

    assign w_sck  = r_sck_sync[SYNC_N-1];
    assign w_cs   = r_cs_sync[SYNC_N-1];
    assign w_mosi = r_mosi_sync[SYNC_N-1];

    assign w_rise   = w_sck & ~r_sck_last;
    assign w_fall   = ~w_sck & r_sck_last;
    assign w_sample = SAMPLE_RISE ? w_rise : w_fall;
    assign w_change = SAMPLE_RISE ? w_fall : w_rise;

    // A CS fall is only trusted once the sync chain has flushed after reset and CS has been
    // seen high, so a reset in mid-frame does not look like a fresh frame start.
    assign w_sof  = r_cs_last & ~w_cs & r_armed;
    assign w_eof  = ~r_cs_last & w_cs;
    assign w_busy = (r_state != StIdle);
    assign w_bit  = w_busy & w_sample & ~w_eof;
    assign w_done = w_bit & (r_bit_cnt == LAST_BIT);
    assign w_word = {r_rx, w_mosi};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else if (i_ena) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; eof wins over a word completing in the same cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_sof) w_state_next = StCmd;
            StCmd:   if (w_done) w_state_next = w_word[REG_W-1] ? StRdata : StWdata;
            default: ;
        endcase
        if (w_eof) begin
            w_state_next = StIdle;
        end
    end

    // Synchronisers, bit counting, shifters and register-bus side
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sck_sync  <= {SYNC_N{SCK_IDLE}};
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_last  <= SCK_IDLE;
            r_cs_last   <= 1'b1;
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
            r_bit_cnt   <= '0;
            r_chg_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_pend   <= 1'b0;
        end else if (i_ena) begin
            r_sck_sync  <= {r_sck_sync[SYNC_N-2:0], i_spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_N-2:0], i_spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_N-2:0], i_spi_mosi};
            r_sck_last  <= w_sck;
            r_cs_last   <= w_cs;

            if (r_flush_cnt != FL_MAX) begin
                r_flush_cnt <= r_flush_cnt + FL_W'(1);
            end else if (w_cs) begin
                r_armed <= 1'b1;
            end

            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_pend <= r_rd_en;

            if (!w_busy || w_eof) begin
                r_bit_cnt <= '0;
            end else if (w_bit) begin
                r_bit_cnt <= w_done ? '0 : r_bit_cnt + CNT_W'(1);
            end
            if (w_bit) begin
                r_rx <= w_word[REG_W-2:0];
            end

            // Address steps the cycle after a write strobe
            if (r_wr_en) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            if (w_done) begin
                case (r_state)
                    StCmd: begin
                        r_addr  <= w_word[ADDR_W-1:0];
                        r_rd_en <= w_word[REG_W-1];
                    end
                    StWdata: begin
                        r_wdata <= w_word;
                        r_wr_en <= 1'b1;
                    end
                    StRdata: begin
                        // Prefetch the next word's data at the following address
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_rd_en <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (!w_busy || w_eof) begin
                r_chg_cnt <= '0;
                r_tx      <= (!w_busy && w_sof) ? i_status : '0;
            end else begin
                if (w_change) begin
                    r_chg_cnt <= (r_chg_cnt == LAST_BIT) ? '0 : r_chg_cnt + CNT_W'(1);
                end
                if (r_rd_pend) begin
                    r_tx <= i_reg_rdata;
                end else if (w_change && (r_chg_cnt != SKIP_CHG)) begin
                    r_tx <= {r_tx[REG_W-2:0], 1'b0};
                end
            end
        end
    end

    assign o_spi_miso     = r_tx[REG_W-1];
    assign o_reg_addr     = r_addr;
    assign o_reg_wdata    = r_wdata;
    assign o_reg_wr_en    = r_wr_en;
    assign o_reg_rd_en    = r_rd_en;
    assign o_frame_active = (r_state != StIdle);

endmodule

// File: tb/tb_spi_reg_burst.sv
// tb_spi_reg_burst: bench for spi_reg_burst. One instance per SPI mode (index = {CPOL,CPHA})
// is driven by a bit-banged SPI master; bus events are logged per instance and compared
// against hand-computed frame vectors, followed by abort, latency and reset sequences.
module tb_spi_reg_burst;

    localparam int H = 8;  // SPI half period in clk cycles

    logic       clk;
    logic       rst;
    logic       ena;
    logic       mosi;
    logic [7:0] status;
    logic       sck      [4];
    logic       cs_n     [4];
    logic       miso     [4];
    logic [6:0] addr     [4];
    logic [7:0] wdata    [4];
    logic       wr_en    [4];
    logic       rd_en    [4];
    logic [7:0] rdata    [4];
    logic       fa       [4];

    // Event log per instance: kind 1 = write, 2 = read
    logic [1:0] ev_kind [4][64];
    logic [7:0] ev_addr [4][64];
    logic [7:0] ev_data [4][64];
    int         ev_cnt  [4];
    int         both_cnt;

    int n_checks;
    int n_err;

    typedef struct {
        int              mode;
        logic [7:0]      status;
        int              nw;
        logic [0:3][7:0] w;
        logic [0:3]      chk;
        logic [0:3][7:0] miso;
        int              nev;
        logic [0:3][1:0] kind;
        logic [0:3][7:0] ea;
        logic [0:3][7:0] ed;
    } vec_t;

    vec_t            vecs [10];
    vec_t            v;
    logic [0:3][7:0] rx;
    logic [7:0]      rb;
    int              base;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_burst #(
            .ADDR_W(7),
            .REG_W (8),
            .CPOL  (g / 2),
            .CPHA  (g % 2),
            .SYNC_N(2)
        ) u_dut (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_ena         (ena),
            .i_spi_clk     (sck[g]),
            .i_spi_cs_n    (cs_n[g]),
            .i_spi_mosi    (mosi),
            .o_spi_miso    (miso[g]),
            .i_status      (status),
            .o_reg_addr    (addr[g]),
            .o_reg_wdata   (wdata[g]),
            .o_reg_wr_en   (wr_en[g]),
            .o_reg_rd_en   (rd_en[g]),
            .i_reg_rdata   (rdata[g]),
            .o_frame_active(fa[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] rd_model(input logic [6:0] a);
        case (a)
            7'h05:   return 8'hA5;
            7'h06:   return 8'h5A;
            default: return {1'b0, a} ^ 8'h3C;
        endcase
    endfunction

    // Register file read port: data valid only in the cycle after the request
    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            rdata[g] <= rd_en[g] ? rd_model(addr[g]) : 8'hEE;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (wr_en[g] && rd_en[g]) both_cnt <= both_cnt + 1;
            if ((wr_en[g] || rd_en[g]) && ev_cnt[g] < 64) begin
                ev_kind[g][ev_cnt[g]] <= wr_en[g] ? 2'd1 : 2'd2;
                ev_addr[g][ev_cnt[g]] <= {1'b0, addr[g]};
                ev_data[g][ev_cnt[g]] <= wr_en[g] ? wdata[g] : 8'h00;
                ev_cnt[g]             <= ev_cnt[g] + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_word(input int m, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rxw);
        logic cpol;
        logic cpha;
        cpol = (m >= 2);
        cpha = (m % 2) != 0;
        rxw  = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = tx[7-i];
                tick(H);
                rxw = {rxw[6:0], miso[m]};
                sck[m] = ~cpol;
                tick(H);
                sck[m] = cpol;
            end else begin
                sck[m] = ~cpol;
                mosi = tx[7-i];
                tick(H);
                rxw = {rxw[6:0], miso[m]};
                sck[m] = cpol;
                tick(H);
            end
        end
        if (!cpha) tick(H);
    endtask

    task automatic run_frame(input int m, input int nw, input logic [0:3][7:0] w,
                             output logic [0:3][7:0] rxf);
        logic [7:0] b;
        rxf = '0;
        cs_n[m] = 1'b0;
        tick(H);
        for (int i = 0; i < nw; i++) begin
            spi_word(m, w[i], 8, b);
            rxf[i] = b;
        end
        cs_n[m] = 1'b1;
        tick(3 * H);
    endtask

    task automatic check_events(input string tag, input int m, input int b, input int nev,
                                input logic [0:3][1:0] kind, input logic [0:3][7:0] ea,
                                input logic [0:3][7:0] ed);
        check($sformatf("%s_evcount", tag), ev_cnt[m] - b, nev);
        for (int i = 0; i < nev && i < ev_cnt[m] - b; i++) begin
            check($sformatf("%s_ev%0d_kind", tag, i), {30'd0, ev_kind[m][b+i]}, {30'd0, kind[i]});
            check($sformatf("%s_ev%0d_addr", tag, i), {24'd0, ev_addr[m][b+i]}, {24'd0, ea[i]});
            check($sformatf("%s_ev%0d_data", tag, i), {24'd0, ev_data[m][b+i]}, {24'd0, ed[i]});
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        both_cnt = 0;
        for (int g = 0; g < 4; g++) begin
            ev_cnt[g] = 0;
            sck[g]    = (g >= 2);
            cs_n[g]   = 1'b1;
        end
        rst    = 1'b1;
        ena    = 1'b1;
        mosi   = 1'b0;
        status = 8'hC3;

        for (int m = 0; m < 4; m++) begin
            vecs[2*m] = '{mode: m, status: 8'hC3, nw: 4, w: 32'h05112233, chk: 4'b1000,
                          miso: 32'hC3000000, nev: 3, kind: 8'b01010100,
                          ea: 32'h05060700, ed: 32'h11223300};
            vecs[2*m+1] = '{mode: m, status: 8'hC3, nw: 3, w: 32'h85000000, chk: 4'b1110,
                            miso: 32'hC3A55A00, nev: 3, kind: 8'b10101000,
                            ea: 32'h05060700, ed: 32'h00000000};
        end
        vecs[8] = '{mode: 1, status: 8'h3C, nw: 3, w: 32'h7FDEAD00, chk: 4'b1000,
                    miso: 32'h3C000000, nev: 2, kind: 8'b01010000,
                    ea: 32'h7F000000, ed: 32'hDEAD0000};
        vecs[9] = '{mode: 2, status: 8'h96, nw: 2, w: 32'hFF000000, chk: 4'b1100,
                    miso: 32'h96430000, nev: 2, kind: 8'b10100000,
                    ea: 32'h7F000000, ed: 32'h00000000};

        tick(5);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rst_miso_m%0d", g), {31'd0, miso[g]}, 0);
            check($sformatf("rst_addr_m%0d", g), {25'd0, addr[g]}, 0);
            check($sformatf("rst_wdata_m%0d", g), {24'd0, wdata[g]}, 0);
            check($sformatf("rst_wr_m%0d", g), {31'd0, wr_en[g]}, 0);
            check($sformatf("rst_rd_m%0d", g), {31'd0, rd_en[g]}, 0);
            check($sformatf("rst_fa_m%0d", g), {31'd0, fa[g]}, 0);
        end
        rst = 1'b0;
        tick(10);

        // frame_active latency: SYNC_N+1 clk after CS fall; empty frame makes no access
        base = ev_cnt[1];
        cs_n[1] = 1'b0;
        tick(2);
        check("fa_lat_early", {31'd0, fa[1]}, 0);
        tick(1);
        check("fa_lat", {31'd0, fa[1]}, 1);
        tick(H);
        cs_n[1] = 1'b1;
        tick(3);
        check("fa_fall", {31'd0, fa[1]}, 0);
        tick(3 * H);
        check("empty_evcount", ev_cnt[1] - base, 0);

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            v      = vecs[i];
            status = v.status;
            base   = ev_cnt[v.mode];
            run_frame(v.mode, v.nw, v.w, rx);
            for (int k = 0; k < 4; k++) begin
                if (v.chk[k]) begin
                    check($sformatf("v%0d_miso%0d", i, k), {24'd0, rx[k]}, {24'd0, v.miso[k]});
                end
            end
            check_events($sformatf("v%0d", i), v.mode, base, v.nev, v.kind, v.ea, v.ed);
            check($sformatf("v%0d_fa_idle", i), {31'd0, fa[v.mode]}, 0);
        end

        // Abort: CS rise after 4 data bits, then a normal frame
        status = 8'hC3;
        base   = ev_cnt[1];
        cs_n[1] = 1'b0;
        tick(H);
        spi_word(1, 8'h10, 8, rb);
        spi_word(1, 8'hF0, 4, rb);
        cs_n[1] = 1'b1;
        tick(3 * H);
        check("abort_fa", {31'd0, fa[1]}, 0);
        check("abort_evcount", ev_cnt[1] - base, 0);
        base = ev_cnt[1];
        run_frame(1, 2, 32'h10770000, rx);
        check_events("after_abort", 1, base, 1, 8'b01000000, 32'h10000000, 32'h77000000);

        // Reset in the middle of a read burst; rest of that frame must be ignored
        cs_n[1] = 1'b0;
        tick(H);
        spi_word(1, 8'hA0, 8, rb);
        spi_word(1, 8'h00, 3, rb);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        base = ev_cnt[1];
        check("rstmid_fa", {31'd0, fa[1]}, 0);
        spi_word(1, 8'h55, 5, rb);
        spi_word(1, 8'h02, 8, rb);
        spi_word(1, 8'h99, 8, rb);
        check("rstmid_fa_hold", {31'd0, fa[1]}, 0);
        cs_n[1] = 1'b1;
        tick(3 * H);
        check("rstmid_evcount", ev_cnt[1] - base, 0);
        base = ev_cnt[1];
        run_frame(1, 2, 32'h02990000, rx);
        check_events("after_rst", 1, base, 1, 8'b01000000, 32'h02000000, 32'h99000000);

        check("wr_rd_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
